seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning datapath width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation, sampled in IDLE only.
REQ-005 The block SHALL have port ALU_control, input, 3 bits: operation code from the ALU control stage.
REQ-006 The block SHALL have port a, input, WIDTH bits: operand A, the shifted value for shift operations.
REQ-007 The block SHALL have port b, input, WIDTH bits: operand B; b[4:0] is the shift amount for shift operations.
REQ-008 The block SHALL have port busy, output, 1 bit: operation in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking result and zero as valid.
REQ-010 The block SHALL have port result, output, WIDTH bits: registered result.
REQ-011 The block SHALL have port zero, output, 1 bit: registered flag, 1 when result equals 0.

Function
REQ-012 The opcodes SHALL be:
- 010: add
- 110: subtract (a-b)
- 000: bitwise AND
- 011: logical shift right
- 001: logical shift left
- any other code: add.
REQ-013 Add and subtract SHALL wrap modulo 2^WIDTH, with no carry or overflow output.
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-015 In IDLE with start=1, the block SHALL latch ALU_control, a and b[4:0] into internal registers; later input changes SHALL NOT affect the operation.
REQ-016 For add, subtract and AND, IDLE SHALL go to DONE at the start edge, with result computed on that edge.
REQ-017 For shifts, IDLE SHALL go to SHIFT, loading the shift register with a and the counter with b[4:0].
REQ-018 In SHIFT, each cycle with counter nonzero SHALL shift the register by one bit (zero fill) and decrement the counter.
REQ-019 When the counter is 0 in SHIFT, the block SHALL move to DONE and copy the shift register to result.
REQ-020 A shift amount of 0 SHALL pass through SHIFT for one cycle and return result=a.
REQ-021 Latency, start edge to done high, SHALL be:
- add, subtract and AND: 1 cycle
- shifts: amount+2 cycles.
REQ-022 In DONE, done SHALL be 1 for exactly one cycle and the FSM SHALL then return to IDLE.
REQ-023 busy SHALL be 1 in SHIFT and in DONE, and 0 in IDLE.
REQ-024 start asserted while busy=1 SHALL be ignored and not queued.
REQ-025 start held high SHALL begin a new operation in the first IDLE cycle after DONE.
REQ-026 result and zero SHALL update only on entry to DONE and SHALL hold until the next DONE.
REQ-027 zero SHALL be computed from the same value written to result.

Reset
REQ-028 When reset=1, the block SHALL asynchronously force:
- state to IDLE
- busy=0, done=0, result=0, zero=0
- internal registers to 0.
REQ-029 Reset asserted during SHIFT or DONE SHALL abort the operation with no done pulse.
REQ-030 After reset deasserts, the first start SHALL be accepted at the next rising edge.

Verification
REQ-031 The bench SHALL apply start with code 010, a=0x00000005, b=0x00000003, and check done one cycle later with result=0x00000008 and zero=0.
REQ-032 The bench SHALL apply code 110, a=b=0x12345678, and check result=0 and zero=1 after 1 cycle; it SHALL then apply a=0, b=1 and check result=0xFFFFFFFF (wrap).
REQ-033 The bench SHALL apply code 001, a=0x00000001, b=0x0000001F, and check done exactly 33 cycles after start with result=0x80000000, and busy high throughout.
REQ-034 The bench SHALL apply code 011, a=0x80000000, b=4, and check result=0x08000000 after 6 cycles; a second start pulsed mid-shift SHALL be ignored (one done only).
REQ-035 The bench SHALL assert reset mid-shift and check the following:
- busy, done and result go to 0 immediately, without waiting for a clock edge
- no done pulse appears afterward
- the next operation with code 000, a=0xF0F0F0F0, b=0xFF00FF00 gives 0xF000F000.
REQ-036 The bench SHALL hold start high with code 111, a=1, b=1, and check back-to-back results of 2, with done pulses separated by one IDLE cycle.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/subtract/AND and bit-serial logical shifts.
// One operation in flight at a time; result and zero are held between done pulses.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ALU_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_shreg;
    logic [4:0]       r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] w_result_nxt;
    logic             w_load_result;
    logic             w_accept;

    // Single-cycle operations; unlisted codes fall back to add.
    function automatic logic [WIDTH-1:0] f_alu(input logic [2:0] op,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] v;
        case (op)
            OP_SUB:  v = x - y;
            OP_AND:  v = x & y;
            OP_ADD:  v = x + y;
            default: v = x + y;
        endcase
        return v;
    endfunction

    function automatic logic f_is_shift(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_SRL);
    endfunction

    assign w_accept = (r_state == S_IDLE) && start;

    // Next-state and result-load decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_result_nxt  = r_result;
        w_load_result = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (f_is_shift(ALU_control)) begin
                        w_state_nxt = S_SHIFT;
                    end else begin
                        w_state_nxt   = S_DONE;
                        w_result_nxt  = f_alu(ALU_control, a, b);
                        w_load_result = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (r_cnt == 5'd0) begin
                    w_state_nxt   = S_DONE;
                    w_result_nxt  = r_shreg;
                    w_load_result = 1'b1;
                end else begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, status flags and held result; busy/done registered from next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= {WIDTH{1'b0}};
            r_zero   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
            if (w_load_result) begin
                r_result <= w_result_nxt;
                r_zero   <= (w_result_nxt == {WIDTH{1'b0}});
            end else begin
                r_result <= r_result;
                r_zero   <= r_zero;
            end
        end
    end

    // Operand capture at start, then one zero-filled bit shift per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op    <= 3'b000;
            r_shreg <= {WIDTH{1'b0}};
            r_cnt   <= 5'd0;
        end else if (w_accept) begin
            r_op    <= ALU_control;
            r_shreg <= a;
            r_cnt   <= b[4:0];
        end else if ((r_state == S_SHIFT) && (r_cnt != 5'd0)) begin
            r_op    <= r_op;
            r_shreg <= (r_op == OP_SRL) ? {1'b0, r_shreg[WIDTH-1:1]}
                                        : {r_shreg[WIDTH-2:0], 1'b0};
            r_cnt   <= r_cnt - 5'd1;
        end else begin
            r_op    <= r_op;
            r_shreg <= r_shreg;
            r_cnt   <= r_cnt;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign zero   = r_zero;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vector table, hand-written corner
// sequences and randomized operations against a plain-arithmetic model.
module tb_seq_alu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  ALU_control;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;

    int checks   = 0;
    int failures = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .ALU_control(ALU_control),
        .a(a), .b(b), .busy(busy), .done(done), .result(result), .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] res;
        logic        z;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: operation defined directly by its arithmetic meaning.
    function automatic void model(input logic [2:0] op, input logic [31:0] ma,
                                  input logic [31:0] mb, output logic [31:0] r,
                                  output int lat);
        int unsigned sh;
        sh = mb % 32;
        case (op)
            3'b110:  r = ma - mb;
            3'b000:  r = ma & mb;
            3'b011:  r = ma >> sh;
            3'b001:  r = ma << sh;
            default: r = ma + mb;
        endcase
        lat = (op == 3'b011 || op == 3'b001) ? int'(sh) + 2 : 1;
    endfunction

    // Launch one operation, scramble inputs afterwards, wait for done (bounded).
    task automatic run_op(input logic [2:0] op, input logic [31:0] ia, input logic [31:0] ib,
                          output logic [31:0] res, output logic z, output int lat,
                          output logic busy_ok);
        @(negedge clk);
        ALU_control = op; a = ia; b = ib; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ALU_control = 3'($urandom); a = $urandom; b = $urandom;
        lat = 1; busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 64) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (done !== 1'b1) lat = -1;
        res = result; z = zero;
    endtask

    // Op plus the IDLE cycle after it: done must drop, busy clear, result hold.
    task automatic op_and_check(input string name, input logic [2:0] op,
                                input logic [31:0] ia, input logic [31:0] ib,
                                input logic [31:0] eres, input logic ez, input int elat);
        logic [31:0] r;
        logic        z;
        int          l;
        logic        bok;
        run_op(op, ia, ib, r, z, l, bok);
        chk({name, ".result"}, 64'(r), 64'(eres));
        chk({name, ".zero"}, 64'(z), 64'(ez));
        chk({name, ".latency"}, 64'(l), 64'(elat));
        chk({name, ".busy"}, 64'(bok), 64'(1'b1));
        @(posedge clk); #1;
        chk({name, ".after"}, {32'(done), 32'(busy)}, 64'd0);
        chk({name, ".hold"}, 64'(result), 64'(eres));
    endtask

    initial begin
        int          n_done;
        int          first;
        int          prev;
        logic        ok;
        logic [2:0]  rop;
        logic [31:0] ra, rb, mres;
        int          mlat;

        vecs[0]  = '{3'b010, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1};
        vecs[1]  = '{3'b110, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1};
        vecs[2]  = '{3'b110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1};
        vecs[3]  = '{3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1};
        vecs[4]  = '{3'b001, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 33};
        vecs[5]  = '{3'b011, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 6};
        vecs[6]  = '{3'b011, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1'b0, 2};
        vecs[7]  = '{3'b101, 32'h0000_0007, 32'h0000_0009, 32'h0000_0010, 1'b0, 1};
        vecs[8]  = '{3'b001, 32'hFFFF_FFFF, 32'h0000_0020, 32'hFFFF_FFFF, 1'b0, 2};
        vecs[9]  = '{3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1};
        vecs[10] = '{3'b011, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 3};

        reset = 1'b1; start = 1'b0; ALU_control = 3'b000; a = 32'd0; b = 32'd0;
        #1;
        chk("reset_state", {28'd0, busy, done, zero, 1'b0, result}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            op_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].va, vecs[i].vb,
                         vecs[i].res, vecs[i].z, vecs[i].lat);
        end

        // Second start while shifting must be neither taken nor queued.
        @(negedge clk);
        ALU_control = 3'b011; a = 32'h8000_0000; b = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0; first = -1;
        for (int c = 1; c <= 16; c++) begin
            if (c == 2) begin ALU_control = 3'b010; a = 32'd1; b = 32'd1; start = 1'b1; end
            if (c == 3) start = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                if (first < 0) first = c;
            end
            @(posedge clk); #1;
        end
        chk("midshift.done_count", 64'(n_done), 64'd1);
        chk("midshift.latency", 64'(first), 64'd6);
        chk("midshift.result", 64'(result), 64'h0800_0000);

        // Reset in the middle of a long shift clears outputs without a clock edge.
        op_and_check("pre_reset", 3'b010, 32'd5, 32'd3, 32'd8, 1'b0, 1);
        @(negedge clk);
        ALU_control = 3'b001; a = 32'd1; b = 32'd31; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        chk("shift.busy_before_reset", 64'(busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", {28'd0, busy, done, zero, 1'b0, result}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) n_done++;
            @(posedge clk); #1;
        end
        chk("abort.no_done", 64'(n_done), 64'd0);
        op_and_check("after_abort_and", 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00,
                     32'hF000_F000, 1'b0, 1);

        // Start on the first edge after reset release.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        op_and_check("first_after_reset", 3'b110, 32'd10, 32'd3, 32'd7, 1'b0, 1);

        // Start held high: back-to-back ops with a single IDLE cycle between pulses.
        @(negedge clk);
        ALU_control = 3'b111; a = 32'd1; b = 32'd1; start = 1'b1;
        n_done = 0; first = -1; prev = -1; ok = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                n_done++;
                if (result !== 32'd2 || zero !== 1'b0) ok = 1'b0;
                if (first < 0) first = c;
                if (prev >= 0 && (c - prev) != 2) ok = 1'b0;
                prev = c;
            end else if (busy !== 1'b0) begin
                ok = 1'b0;
            end
        end
        start = 1'b0;
        chk("b2b.count", 64'(n_done), 64'd5);
        chk("b2b.first", 64'(first), 64'd1);
        chk("b2b.pattern", 64'(ok), 64'd1);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom);
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(31, 0)) : $urandom;
            if (i % 10 == 0) rb = ra;
            model(rop, ra, rb, mres, mlat);
            op_and_check($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb,
                         mres, (mres == 32'd0), mlat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
